fixedpoint_div: RTL and testbench

// - Sequential unsigned fixed-point divider: quotient = dividend / divisor.
// - Inverse of the team's fixed-point multiplier: Q6.2 product back to Q3.5 operand, given the other Q3.5 operand.
// - Restoring shift-subtract at 1 quotient bit/cycle; valid/ready on both sides.
// - Used where the datapath needs to undo a scaling product.

---
 rtl/fixedpoint_pkg.sv | 21 ++
 rtl/fixedpoint_round_sat.sv | 19 +
 rtl/fixedpoint_div.sv | 140 ++++++++++++++
 tb/tb_fixedpoint_div.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fixedpoint_pkg.sv
// rtl/fixedpoint_pkg.sv - Q-format constants and FSM encoding shared by the fixed-point divider and multiplier.
package fixedpoint_pkg;

  localparam int DW       = 8;
  localparam int FRAC_DVD = 2;
  localparam int FRAC_DVS = 5;
  localparam int FRAC_Q   = 5;

  // Extra left shift of the dividend so the quotient lands in Q3.5; one more bit feeds rounding.
  localparam int SHIFT = FRAC_Q + FRAC_DVS - FRAC_DVD;
  localparam int NB    = DW + SHIFT + 1;
  localparam int CNT_W = $clog2(NB);

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t CALC  = 2'd1;
  localparam state_t ROUND = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/fixedpoint_round_sat.sv
// rtl/fixedpoint_round_sat.sv - Half-up rounding of a raw quotient with one guard bit, saturating to DW bits.
module fixedpoint_round_sat
  import fixedpoint_pkg::*;
(
  input  logic [NB-1:0] raw,
  output logic [DW-1:0] quotient,
  output logic          sat
);

  logic [NB-1:0] rounded;

  always_comb begin
    // (raw + 1) >> 1 without needing an extra carry bit.
    rounded  = {1'b0, raw[NB-1:1]} + {{(NB-1){1'b0}}, raw[0]};
    sat      = |rounded[NB-1:DW];
    quotient = sat ? {DW{1'b1}} : rounded[DW-1:0];
  end

endmodule

// File: rtl/fixedpoint_div.sv
// rtl/fixedpoint_div.sv - Sequential restoring divider, Q6.2 / Q3.5 -> Q3.5, one quotient bit per cycle.
module fixedpoint_div
  import fixedpoint_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic          sat,
  output logic          dbz
);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0]    n_q, n_d;
  logic [NB-1:0]    raw_q, raw_d;
  logic [DW:0]      rem_q, rem_d;
  logic [DW-1:0]    dvs_q, dvs_d;
  logic [DW-1:0]    quot_q, quot_d;
  logic             sat_q, sat_d;
  logic             dbz_q, dbz_d;
  logic             vld_q, vld_d;
  logic             rdy_q, rdy_d;

  logic [DW+1:0] rem_sh;
  logic [DW:0]   rem_sub;
  logic          ge;
  logic [DW-1:0] rs_quot;
  logic          rs_sat;

  fixedpoint_round_sat u_round_sat (
    .raw      (raw_q),
    .quotient (rs_quot),
    .sat      (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    raw_d   = raw_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;
    vld_d   = vld_q;

    rem_sh  = {rem_q, n_q[NB-1]};
    ge      = rem_sh >= {2'b00, dvs_q};
    rem_sub = rem_sh[DW:0] - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          n_d   = {dividend, {(SHIFT + 1){1'b0}}};
          rem_d = '0;
          raw_d = '0;
          cnt_d = CNT_W'(NB - 1);
          if (divisor == '0) begin
            quot_d  = {DW{1'b1}};
            sat_d   = 1'b0;
            dbz_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = ge ? rem_sub : rem_sh[DW:0];
        raw_d = {raw_q[NB-2:0], ge};
        n_d   = {n_q[NB-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ROUND: begin
        quot_d  = rs_quot;
        sat_d   = rs_sat;
        dbz_d   = 1'b0;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      raw_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      raw_q   <= raw_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign quotient  = quot_q;
  assign sat       = sat_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_fixedpoint_div.sv
// tb/tb_fixedpoint_div.sv - Self-checking bench for fixedpoint_div against an arithmetic reference model.
module tb_fixedpoint_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic       sat;
  logic       dbz;

  int vectors     = 0;
  int miscompares = 0;

  fixedpoint_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .sat       (sat),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q6.2 / Q3.5 -> Q3.5: scale dividend by 2^9, divide, round half-up, saturate.
  task automatic model(input int dvd, input int dvs, output logic [7:0] q, output logic s, output logic z);
    int raw, r;
    if (dvs == 0) begin
      q = 8'hFF; s = 1'b0; z = 1'b1;
    end else begin
      raw = (dvd * 512) / dvs;
      r   = (raw + 1) / 2;
      z   = 1'b0;
      if (r > 255) begin
        q = 8'hFF; s = 1'b1;
      end else begin
        q = r[7:0]; s = 1'b0;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input int hold, input bit poke);
    logic [7:0] eq;
    logic       es, ez;
    int         lat, w;
    model(int'(dvd), int'(dvs), eq, es, ez);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", {31'b0, in_ready}, 32'd1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    if (dvs != 8'd0) check("ready_low_busy", {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (poke && lat >= 1 && lat <= 8) begin
        in_valid = 1'b1;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency_after_accept", lat, (dvs == 8'd0) ? 32'd0 : 32'd18);
    check("quotient", {24'b0, quotient}, {24'b0, eq});
    check("sat_dbz", {30'b0, sat, dbz}, {30'b0, es, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {21'b0, out_valid, sat, dbz, quotient}, {21'b0, 1'b1, es, ez, eq});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid_ready", {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] rd, rv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_state", {20'b0, in_ready, out_valid, sat, dbz, quotient}, {20'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd4,   8'd32,  0, 1'b0);
    run_op(8'd2,   8'd64,  0, 1'b0);
    run_op(8'd1,   8'd96,  0, 1'b0);
    run_op(8'd1,   8'd224, 0, 1'b0);
    run_op(8'd255, 8'd1,   0, 1'b0);
    run_op(8'd77,  8'd0,   0, 1'b0);
    run_op(8'd4,   8'd32,  5, 1'b0);
    run_op(8'd200, 8'd33,  0, 1'b1);
    run_op(8'd9,   8'd0,   3, 1'b0);

    // Abort at CALC cycle 7 after a nonzero result is already held in the output regs.
    run_op(8'd100, 8'd3, 0, 1'b0);
    dividend = 8'd50;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {20'b0, in_ready, out_valid, sat, dbz, quotient}, {20'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("no_stale_result", {31'b0, out_valid}, 32'd0);
    run_op(8'd2, 8'd64, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(rd, rv, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
